dct_row_collector: RTL
======================

Name: dct_row_collector

Overview:
- Downstream of the 8-lane row×column floating-point dot-product stage; consumes its 32-bit result and validity pulse.
- Packs 8 consecutive results into one 256-bit row word, in the same lane layout the multiplier stage uses (element k at bits [32k+31:32k]).
- Double-buffered, because the upstream stage has no backpressure.
- Presents completed rows on a valid/ready interface and tags the last row of each 8×8 block.

Parameters:
- WIDTH, 32, bits per element (IEEE-754 single).
- LANES, 8, elements per row.
- ROWS, 8, rows per block; sets the out_last period.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  WIDTH  dot-product result.
- in_valid  in  1  one-cycle qualifier for in_data; no ready is returned.
- out_row  out  WIDTH*LANES  packed row; lane k at [WIDTH*k+WIDTH-1:WIDTH*k].
- out_valid  out  1  out_row holds a complete row.
- out_ready  in  1  consumer accepts the row.
- out_last  out  1  qualifies the current out_row as row ROWS-1 of the block.
- overflow  out  1  sticky: a word was dropped.

Behaviour:
- Reset (clk edge with rst_n=0) clears:
  - out_valid=0, out_last=0, overflow=0, out_row=0.
  - Both buffer full flags, lane counter wcnt=0, write select wsel=0, read select rsel=0, row counter ridx=0.
  - A reset mid-row discards partial and completed rows.
- Storage: two row buffers, buf[0] and buf[1], each with a full flag.
- Write side, on each clk with in_valid=1 and full[wsel]=0:
  - buf[wsel] lane wcnt <= in_data.
  - If wcnt==LANES-1: full[wsel]<=1, wsel toggles, wcnt<=0. Otherwise wcnt++.
- Write side, with in_valid=1 and full[wsel]=1:
  - Word dropped; wcnt unchanged; overflow<=1 until reset.
- Read side:
  - out_valid = full[rsel]; out_row = buf[rsel]; out_last = out_valid && (ridx==ROWS-1).
  - All three are driven from registers/flags; no combinational path from in_* to out_*.
- Transfer, on a cycle with out_valid && out_ready:
  - full[rsel]<=0, rsel toggles.
  - ridx <= (ridx==ROWS-1) ? 0 : ridx+1.
- Latency: the 8th word of a row is written at edge N; out_valid=1 and out_row valid after edge N, i.e. visible in cycle N+1.
- Simultaneous fill-complete on buf[wsel] and drain of buf[rsel]:
  - Both take effect in the same cycle.
  - They cannot target the same buffer, since a write needs full[wsel]=0 and a drain needs full[rsel]=1.
- When both buffers drain back-to-back with out_ready held high, out_valid stays high across the boundary. No bubble is required.
- out_row is stable while out_valid=1 && out_ready=0.
- in_valid=0 cycles: no state change on the write side. Gaps between words of a row are legal.
- Throughput: sustains 1 word/cycle indefinitely if out_ready is high at least 1 cycle in every LANES.

Optional Feature:
- Macro DCT_ROW_COLLECTOR_DROP_CNT_EN.
- When defined:
  - Adds output port drop_cnt, 16 bits, out.
  - drop_cnt increments on every dropped word and saturates at 16'hFFFF.
  - Reset value 0.
- When undefined:
  - The port and counter are absent.
  - Only the sticky overflow flag reports drops.

Test Plan:
- Basic pack: reset, then feed words 32'h3F800000+k for k=0..7 on consecutive cycles with out_ready=1.
  - Required: out_valid=1 one cycle after the 8th word.
  - Required: out_row[31:0]=3F800000 and out_row[255:224]=3F800007; out_last=0; out_valid drops the next cycle.
- Block tagging: stream 64 words with out_ready=1.
  - Required: 8 rows are accepted, and out_last=1 only on the 8th row.
  - Required: a 9th row restarts at ridx=0 with out_last=0.
- Backpressure/double-buffer: out_ready=0, feed 16 words.
  - Required: out_valid=1 with row0 stable; no overflow.
  - Then raise out_ready for 2 cycles. Required: row0 then row1 are presented back-to-back, then out_valid=0.
- Overflow: out_ready=0, feed 17 words, 17th = 32'hDEADBEEF.
  - Required: overflow=1, and drop_cnt=1 if enabled.
  - Drain both rows. Required: contents are words 0..15 only; 32'hDEADBEEF never appears.
- Gapped input plus mid-operation reset: feed words with random 0–3 cycle gaps and confirm correct packing; then assert rst_n=0 after 5 words of a row.
  - Required: out_valid=0, overflow=0.
  - Required: the next 8 words form a fresh row at lanes 0..7.

Source files
------------

// File: rtl/dct_row_collector.sv
// dct_row_collector
//   Collects LANES consecutive WIDTH-bit dot-product results into one packed
//   row word (lane k at [WIDTH*k+WIDTH-1:WIDTH*k]) and presents completed rows
//   on a valid/ready interface. Two row buffers absorb the lack of upstream
//   backpressure; out_last tags row ROWS-1 of every block.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data    dot-product result
//   in_valid   one-cycle qualifier for in_data (no ready returned)
//   out_row    packed row from the read-side buffer
//   out_valid  out_row holds a complete row
//   out_ready  consumer accepts the row
//   out_last   current row is the last row of its block
//   overflow   sticky: a word arrived while the write buffer was still full
//   drop_cnt   saturating count of dropped words
//              (only with DCT_ROW_COLLECTOR_DROP_CNT_EN defined)
//
// Optional feature macro: DCT_ROW_COLLECTOR_DROP_CNT_EN

module dct_row_collector #(
    parameter int WIDTH = 32,
    parameter int LANES = 8,
    parameter int ROWS  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic [WIDTH*LANES-1:0]   out_row,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     overflow
`ifdef DCT_ROW_COLLECTOR_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);

    localparam int WCNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int RIDX_W = (ROWS  > 1) ? $clog2(ROWS)  : 1;

    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(LANES - 1);
    localparam logic [RIDX_W-1:0] RIDX_LAST = RIDX_W'(ROWS - 1);

    logic [WIDTH*LANES-1:0] row_buf_q [2];
    logic [WIDTH*LANES-1:0] row_buf_d [2];
    logic [1:0]             full_q, full_d;
    logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
    logic                   wsel_q, wsel_d;
    logic                   rsel_q, rsel_d;
    logic [RIDX_W-1:0]      ridx_q, ridx_d;
    logic                   overflow_q, overflow_d;
`ifdef DCT_ROW_COLLECTOR_DROP_CNT_EN
    logic [15:0]            drop_cnt_q, drop_cnt_d;
`endif

    always_comb begin
        row_buf_d  = row_buf_q;
        full_d     = full_q;
        wcnt_d     = wcnt_q;
        wsel_d     = wsel_q;
        rsel_d     = rsel_q;
        ridx_d     = ridx_q;
        overflow_d = overflow_q;
`ifdef DCT_ROW_COLLECTOR_DROP_CNT_EN
        drop_cnt_d = drop_cnt_q;
`endif

        // Write side: fill buf[wsel] lane by lane, drop while it is still full.
        if (in_valid) begin
            if (!full_q[wsel_q]) begin
                row_buf_d[wsel_q][int'(wcnt_q)*WIDTH +: WIDTH] = in_data;
                if (wcnt_q == WCNT_LAST) begin
                    full_d[wsel_q] = 1'b1;
                    wsel_d         = ~wsel_q;
                    wcnt_d         = '0;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end else begin
                overflow_d = 1'b1;
`ifdef DCT_ROW_COLLECTOR_DROP_CNT_EN
                if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
`endif
            end
        end

        // Read side: a fill completing on buf[wsel] and a drain of buf[rsel]
        // never hit the same buffer (fill needs !full, drain needs full), so
        // both full_d updates can land in the same cycle.
        if (full_q[rsel_q] && out_ready) begin
            full_d[rsel_q] = 1'b0;
            rsel_d         = ~rsel_q;
            ridx_d         = (ridx_q == RIDX_LAST) ? '0 : ridx_q + RIDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_buf_q  <= '{default: '0};
            full_q     <= '0;
            wcnt_q     <= '0;
            wsel_q     <= 1'b0;
            rsel_q     <= 1'b0;
            ridx_q     <= '0;
            overflow_q <= 1'b0;
`ifdef DCT_ROW_COLLECTOR_DROP_CNT_EN
            drop_cnt_q <= '0;
`endif
        end else begin
            row_buf_q  <= row_buf_d;
            full_q     <= full_d;
            wcnt_q     <= wcnt_d;
            wsel_q     <= wsel_d;
            rsel_q     <= rsel_d;
            ridx_q     <= ridx_d;
            overflow_q <= overflow_d;
`ifdef DCT_ROW_COLLECTOR_DROP_CNT_EN
            drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

    // Outputs come straight from state; nothing from in_* reaches them.
    assign out_row   = row_buf_q[rsel_q];
    assign out_valid = full_q[rsel_q];
    assign out_last  = full_q[rsel_q] && (ridx_q == RIDX_LAST);
    assign overflow  = overflow_q;
`ifdef DCT_ROW_COLLECTOR_DROP_CNT_EN
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule
